ibex_ifetch_capture_fifo: RTL



---
 rtl/ibex_ifetch_capture_pkg.sv | 24 ++
 rtl/ibex_ifetch_capture_ram.sv | 30 +++
 rtl/ibex_ifetch_capture_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ibex_ifetch_capture_pkg.sv
// Shared defaults, entry layout and helpers for the instruction-fetch capture FIFO.
package ibex_ifetch_capture_pkg;

   localparam int unsigned AddrWidthDef    = 32;
   localparam int unsigned DataWidthDef    = 32;
   localparam int unsigned SeqWidthDef     = 16;
   localparam int unsigned DropCntWidthDef = 8;

   typedef struct packed {
      logic [AddrWidthDef-1:0] addr;
      logic [DataWidthDef-1:0] rdata;
      logic                    err;
      logic                    err_plus2;
      logic [SeqWidthDef-1:0]  seq;
   } capture_entry_t;

   // Increment that sticks at the all-ones value of a counter of the given width.
   function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
      logic [63:0] max_val;
      max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (val >= max_val) ? max_val : val + 64'd1;
   endfunction

endpackage

// File: rtl/ibex_ifetch_capture_ram.sv
// Depth x Width register-array storage: one synchronous write port, one asynchronous read port.
module ibex_ifetch_capture_ram #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 82
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(Depth)-1:0] waddr,
   input  logic [Width-1:0]         wdata,
   input  logic [$clog2(Depth)-1:0] raddr,
   output logic [Width-1:0]         rdata
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/ibex_ifetch_capture_fifo.sv
// Captures every completed fetch handshake into a FIFO with sequence numbering,
// optional error-only filtering, saturating drop accounting and synchronous flush.
module ibex_ifetch_capture_fifo
   import ibex_ifetch_capture_pkg::*;
#(
   parameter int unsigned AddrWidth    = AddrWidthDef,
   parameter int unsigned DataWidth    = DataWidthDef,
   parameter int unsigned Depth        = 8,
   parameter int unsigned SeqWidth     = SeqWidthDef,
   parameter int unsigned DropCntWidth = DropCntWidthDef,
   parameter bit          ErrOnly      = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_valid,
   input  logic                       fetch_ready,
   input  logic [AddrWidth-1:0]       fetch_addr,
   input  logic [DataWidth-1:0]       fetch_rdata,
   input  logic                       fetch_err,
   input  logic                       fetch_err_plus2,
   input  logic                       clear,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [AddrWidth-1:0]       out_addr,
   output logic [DataWidth-1:0]       out_rdata,
   output logic                       out_err,
   output logic                       out_err_plus2,
   output logic [SeqWidth-1:0]        out_seq,
   output logic [$clog2(Depth):0]     level,
   output logic [DropCntWidth-1:0]    drop_cnt
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] rdata;
      logic                 err;
      logic                 err_plus2;
      logic [SeqWidth-1:0]  seq;
   } entry_t;

   localparam int unsigned EntryW = $bits(entry_t);

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
      $error("ibex_ifetch_capture_fifo: Depth must be a power of two and at least 2");
   end

   logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]         level_q, level_d;
   logic [SeqWidth-1:0]     seq_q, seq_d;
   logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
   logic                    xfer, qual, full, empty, push, pop, overflow, wr_en;
   entry_t                  wr_entry, head;
   logic [EntryW-1:0]       ram_rdata;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      xfer     = fetch_valid & fetch_ready;
      qual     = xfer & (!ErrOnly | fetch_err | fetch_err_plus2);
      full     = (level_q == LvlW'(Depth));
      empty    = (level_q == '0);
      pop      = !empty & out_ready;
      push     = qual & (!full | pop);
      overflow = qual & full & !pop;
      wr_en    = push & !clear;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      seq_d      = seq_q;
      drop_cnt_d = drop_cnt_q;

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         seq_d      = '0;
         drop_cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      level_d = level_q + 1'b1;
         else if (!push && pop) level_d = level_q - 1'b1;
         if (qual) seq_d = seq_q + 1'b1;
         if (overflow) drop_cnt_d = DropCntWidth'(sat_inc(64'(drop_cnt_q), DropCntWidth));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         seq_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         seq_q      <= seq_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      wr_entry           = '0;
      wr_entry.addr      = fetch_addr;
      wr_entry.rdata     = fetch_rdata;
      wr_entry.err       = fetch_err;
      wr_entry.err_plus2 = fetch_err_plus2;
      wr_entry.seq       = seq_q;
   end

   ibex_ifetch_capture_ram #(
      .Depth (Depth),
      .Width (EntryW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign head = entry_t'(ram_rdata);

   // Storage is not reset, so head fields are masked to zero while empty.
   always_comb begin
      out_valid     = !empty;
      out_addr      = out_valid ? head.addr      : '0;
      out_rdata     = out_valid ? head.rdata     : '0;
      out_err       = out_valid ? head.err       : 1'b0;
      out_err_plus2 = out_valid ? head.err_plus2 : 1'b0;
      out_seq       = out_valid ? head.seq       : '0;
   end

   assign level    = level_q;
   assign drop_cnt = drop_cnt_q;

   a_head_stable: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready && !clear) |=>
         $stable({out_addr, out_rdata, out_err, out_err_plus2, out_seq}));

   a_level_bound: assert property (@(posedge clk) disable iff (reset)
      level_q <= LvlW'(Depth));

   a_no_push_full: assert property (@(posedge clk) disable iff (reset)
      !(push && full && !pop));

endmodule
